// File: rtl/ac2_seq.sv
// ac2_seq: bit-serial dot-product sequencer feeding the AC2 shift-accumulate register.
// Weights are consumed LSB first; the MSB partial sum is subtracted (two's complement weight).
module ac2_seq #(
    parameter int M  = 16,
    parameter int Pa = 8,
    parameter int Pw = 4,
    localparam int L  = $clog2(M) + Pa + 1,
    localparam int KW = $clog2(Pw)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [M*Pa-1:0] act,
    input  logic [M*Pw-1:0] wgt,
    input  logic            clr,
    input  logic [L-1:0]    acc_fb,
    output logic [L-1:0]    inr_ac2,
    output logic            valid,
    output logic            w_en,
    output logic            s_en,
    output logic            cl_en,
    output logic            done
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state, state_nx;
    logic [KW-1:0]   k;
    logic [M*Pa-1:0] ops;
    logic [M*Pw-1:0] wsr;
    logic [L-1:0]    psum, acc;
    logic            accept, last;

    assign in_ready = state != SHIFT;
    assign accept   = in_valid & in_ready;
    assign last     = k == KW'(Pw - 1);
    assign valid    = state == SHIFT;
    assign w_en     = valid;
    assign s_en     = valid;
    assign done     = state == DONE;

    always_comb begin
        state_nx = accept ? SHIFT : (state == SHIFT ? (last ? DONE : SHIFT) : IDLE);
    end

    // Whole-vector shift is safe: bits leaking between lanes never reach a lane's LSB in time.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            ops   <= '0;
            wsr   <= '0;
            cl_en <= 1'b0;
        end else begin
            state <= state_nx;
            cl_en <= (state == IDLE) & clr & ~accept;
            if (accept) begin
                ops <= act;
                wsr <= wgt;
                k   <= '0;
            end else if (state == SHIFT) begin
                wsr <= wsr >> 1;
                k   <= k + 1'b1;
            end
        end
    end

    always_comb begin
        psum = '0;
        for (int i = 0; i < M; i++)
            if (wsr[i*Pw]) psum = psum + L'($signed(ops[i*Pa +: Pa]));
        acc     = (k == '0) ? '0 : acc_fb;
        inr_ac2 = (state != SHIFT) ? '0 : (last ? acc - psum : acc + psum);
    end
endmodule
